tap_axil_bridge: RTL and testbench

TAP_AXIL_BRIDGE -- requirements
Module: tap_axil_bridge

---
 rtl/tap_axil_bridge.sv | 181 ++++++++++++++++++
 tb/tb_tap_axil_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_axil_bridge.sv
// AXI-Lite slave onto the FIR coefficient BRAM, shared with the FIR engine (engine wins in IDLE).
// Optional TAP_ADDR_CHECK_EN: in-window indices >= pTAP_NUM get no BRAM access and a 2'b10 response.
//   state   | meaning
//   IDLE    | engine may own BRAM; accept write (priority) or read
//   WR      | one-cycle BRAM write strobe
//   WRESP   | bvalid held until bready
//   RD_ADDR | BRAM address presented
//   RD_WAIT | BRAM data returns, captured into rdata_q
//   RD_DATA | rvalid held until rready
module tap_axil_bridge #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst_n,
  input  logic [pADDR_WIDTH-1:0]     awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [pDATA_WIDTH-1:0]     wdata,
  input  logic [pDATA_WIDTH/8-1:0]   wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [pADDR_WIDTH-1:0]     araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [pDATA_WIDTH-1:0]     rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [pDATA_WIDTH/8-1:0]   tap_WE,
  output logic                       tap_EN,
  output logic [pDATA_WIDTH-1:0]     tap_Di,
  output logic [pADDR_WIDTH-1:0]     tap_A,
  input  logic [pDATA_WIDTH-1:0]     tap_Do,
  input  logic                       eng_active,
  input  logic [pADDR_WIDTH-1:0]     eng_A,
  output logic                       eng_grant
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ADDR, RD_WAIT, RD_DATA} state_t;

  localparam logic [pADDR_WIDTH-1:0] WIN_LO = pADDR_WIDTH'('h080);
  localparam logic [pADDR_WIDTH-1:0] WIN_HI = pADDR_WIDTH'('h0FF);
  localparam logic [pADDR_WIDTH-1:0] A_MASK = ~pADDR_WIDTH'(3);

  state_t state_q, state_d;
  logic [pADDR_WIDTH-1:0]   addr_q;
  logic [pDATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [pDATA_WIDTH/8-1:0] wstrb_q;
  logic                     ok_q, err_q;
  logic                     acc_w, acc_r;
  logic [pADDR_WIDTH-1:0]   req_addr, req_off;
  logic                     req_win, req_ok, req_err;

  always_comb begin
    req_addr = (awvalid && wvalid) ? awaddr : araddr;
    req_win  = (req_addr >= WIN_LO) && (req_addr <= WIN_HI);
    req_off  = (req_addr - WIN_LO) & A_MASK;
`ifdef TAP_ADDR_CHECK_EN
    req_ok   = req_win && ((req_off >> 2) < pADDR_WIDTH'(pTAP_NUM));
    req_err  = req_win && !req_ok;
`else
    req_ok   = req_win;
    req_err  = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_w     = 1'b0;
    acc_r     = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    arready   = 1'b0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    rvalid    = 1'b0;
    rresp     = 2'b00;
    rdata     = '0;
    tap_WE    = '0;
    tap_EN    = 1'b0;
    tap_Di    = '0;
    tap_A     = '0;
    eng_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (eng_active) begin
          eng_grant = 1'b1;
          tap_EN    = 1'b1;
          tap_A     = eng_A;
        end else if (awvalid && wvalid) begin
          awready = 1'b1;
          wready  = 1'b1;
          acc_w   = 1'b1;
          state_d = WR;
        end else if (arvalid) begin
          arready = 1'b1;
          acc_r   = 1'b1;
          state_d = RD_ADDR;
        end
      end
      WR: begin
        tap_EN  = ok_q;
        tap_WE  = ok_q ? wstrb_q : '0;
        tap_A   = ok_q ? addr_q : '0;
        tap_Di  = ok_q ? wdata_q : '0;
        state_d = WRESP;
      end
      WRESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (bready) state_d = IDLE;
      end
      RD_ADDR: begin
        tap_EN  = ok_q;
        tap_A   = ok_q ? addr_q : '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        tap_EN  = ok_q;
        tap_A   = ok_q ? addr_q : '0;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rdata  = rdata_q;
        rresp  = err_q ? 2'b10 : 2'b00;
        if (rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs must read zero during reset even while the clock is stopped.
    if (!axis_rst_n) begin
      state_d   = IDLE;
      acc_w     = 1'b0;
      acc_r     = 1'b0;
      awready   = 1'b0;
      wready    = 1'b0;
      arready   = 1'b0;
      bvalid    = 1'b0;
      bresp     = 2'b00;
      rvalid    = 1'b0;
      rresp     = 2'b00;
      rdata     = '0;
      tap_WE    = '0;
      tap_EN    = 1'b0;
      tap_Di    = '0;
      tap_A     = '0;
      eng_grant = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_w || acc_r) begin
        addr_q <= req_off;
        ok_q   <= req_ok;
        err_q  <= req_err;
      end
      if (acc_w) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (state_q == RD_WAIT) rdata_q <= ok_q ? tap_Do : '0;
    end
  end

endmodule

// File: tb/tb_tap_axil_bridge.sv
// Randomized scoreboard bench for tap_axil_bridge with a word-array reference model and BRAM model.
module tb_tap_axil_bridge;

  localparam int TAPN = 11;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic [11:0] awaddr, araddr, tap_A, eng_A;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, tap_Di, tap_Do;
  logic [3:0]  wstrb, tap_WE;
  logic [1:0]  bresp, rresp;
  logic        tap_EN, eng_active, eng_grant;

  tap_axil_bridge dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_active(eng_active), .eng_A(eng_A), .eng_grant(eng_grant)
  );

  always #5 axis_clk = ~axis_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // BRAM model: synchronous, data one cycle after address, zero when not enabled.
  logic [31:0] bmem [32] = '{default: 32'h0};
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) bmem[tap_A[6:2]][b*8 +: 8] <= tap_Di[b*8 +: 8];
      tap_Do <= bmem[tap_A[6:2]];
    end else begin
      tap_Do <= 32'h0;
    end
  end

  // Reference model: word array updated at write acceptance.
  logic [31:0] ref_mem [32] = '{default: 32'h0};

  function automatic bit f_win(input logic [11:0] a);
    return (a >= 12'h080) && (a <= 12'h0FF);
  endfunction
  function automatic int f_idx(input logic [11:0] a);
    return int'((a - 12'h080) >> 2);
  endfunction
  function automatic bit f_ok(input logic [11:0] a);
`ifdef TAP_ADDR_CHECK_EN
    return f_win(a) && (f_idx(a) < TAPN);
`else
    return f_win(a);
`endif
  endfunction
  function automatic logic [1:0] f_resp(input logic [11:0] a);
    return (f_win(a) && !f_ok(a)) ? 2'b10 : 2'b00;
  endfunction

  typedef struct { logic [31:0] d; logic [1:0] r; } rexp_t;
  rexp_t      rq[$];
  logic [1:0] wq[$];
  time        b_hs_time = 0;
  time        ar_time = 0;
  int         reads_done = 0;
  int         ready_mode = 0;  // 0 random, 1 rready low, 2 rready high

  always @(negedge axis_clk) begin
    if (rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 32'(rvalid), 32'h0);
      else begin
        rexp_t e;
        e = rq.pop_front();
        chk("rdata", rdata, e.d);
        chk("rresp", 32'(rresp), 32'(e.r));
      end
    end
    if (bvalid && bready) begin
      b_hs_time = $time;
      if (wq.size() == 0) chk("b_unexpected", 32'(bvalid), 32'h0);
      else chk("bresp", 32'(bresp), 32'(wq.pop_front()));
    end
  end

  always @(posedge axis_clk) begin
    #2;
    bready = ($urandom % 3) != 0;
    rready = (ready_mode == 2) || ((ready_mode == 0) && (($urandom % 3) != 0));
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge axis_clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge axis_clk);
    while (!(awready && wready) && n < 200) begin @(negedge axis_clk); n++; end
    chk("aw_accept", 32'(awready && wready), 32'h1);
    if (!(awready && wready)) begin awvalid = 1'b0; wvalid = 1'b0; return; end
    if (f_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[f_idx(a)][b*8 +: 8] = d[b*8 +: 8];
    wq.push_back(f_resp(a));
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_tap_we", 32'(tap_WE), f_ok(a) ? 32'(s) : 32'h0);
    chk("wr_tap_en", 32'(tap_EN), 32'(f_ok(a)));
    if (f_ok(a)) begin
      chk("wr_tap_a", 32'(tap_A), 32'((a - 12'h080) & 12'hFFC));
      chk("wr_tap_di", tap_Di, d);
    end
    @(posedge axis_clk); #1;
    chk("wr_we_once", 32'(tap_WE), 32'h0);
    n = 0;
    while (wq.size() != 0 && n < 200) begin @(negedge axis_clk); n++; end
    chk("b_drain", 32'(wq.size()), 32'h0);
  endtask

  task automatic axi_read(input logic [11:0] a);
    int n;
    rexp_t e;
    @(posedge axis_clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge axis_clk);
    while (!arready && n < 200) begin @(negedge axis_clk); n++; end
    chk("ar_accept", 32'(arready), 32'h1);
    if (!arready) begin arvalid = 1'b0; return; end
    ar_time = $time;
    e.d = f_ok(a) ? ref_mem[f_idx(a)] : 32'h0;
    e.r = f_resp(a);
    rq.push_back(e);
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge axis_clk); n++; end while (!rvalid && n < 200);
    chk("rd_latency", n, 32'd3);
    n = 0;
    while (rq.size() != 0 && n < 400) begin @(negedge axis_clk); n++; end
    chk("r_drain", 32'(rq.size()), 32'h0);
    reads_done++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, target;
    axis_rst_n = 1'b0;
    eng_active = 1'b1; eng_A = 12'h004;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 12'h080; araddr = 12'h080; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    repeat (3) @(negedge axis_clk);
    chk("rst_eng_grant", 32'(eng_grant), 32'h0);
    chk("rst_awready", 32'(awready), 32'h0);
    chk("rst_wready", 32'(wready), 32'h0);
    chk("rst_arready", 32'(arready), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_tap_en", 32'(tap_EN), 32'h0);
    chk("rst_tap_we", 32'(tap_WE), 32'h0);
    chk("rst_tap_a", 32'(tap_A), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; eng_active = 1'b0;
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    repeat (2) @(negedge axis_clk);

    axi_write(12'h080, 32'hDEAD_BEEF, 4'hF);
    axi_read(12'h080);
    axi_write(12'h084, 32'hAAAA_AAAA, 4'hF);
    axi_write(12'h084, 32'h1122_3344, 4'h3);
    axi_read(12'h084);
    chk("partial_model", ref_mem[1], 32'hAAAA_3344);

    fork
      axi_write(12'h088, 32'h0BAD_F00D, 4'hF);
      axi_read(12'h080);
    join
    chk("wr_before_rd", 32'(ar_time > b_hs_time), 32'h1);

    ready_mode = 1;
    target = reads_done + 1;
    fork axi_read(12'h080); join_none
    n = 0;
    @(negedge axis_clk);
    while (!rvalid && n < 50) begin @(negedge axis_clk); n++; end
    @(posedge axis_clk); #1;
    eng_A = 12'h008; eng_active = 1'b1;
    repeat (3) begin
      @(negedge axis_clk);
      chk("eng_wait_grant", 32'(eng_grant), 32'h0);
      chk("eng_wait_rvalid", 32'(rvalid), 32'h1);
    end
    ready_mode = 2;
    n = 0;
    while (!(rvalid && rready) && n < 50) begin @(negedge axis_clk); n++; end
    @(negedge axis_clk);
    chk("eng_grant", 32'(eng_grant), 32'h1);
    chk("eng_tap_a", 32'(tap_A), 32'h008);
    chk("eng_tap_en", 32'(tap_EN), 32'h1);
    chk("eng_tap_we", 32'(tap_WE), 32'h0);
    target++;
    fork axi_read(12'h084); join_none
    repeat (5) begin
      @(negedge axis_clk);
      chk("eng_ar_stall", 32'(arready), 32'h0);
    end
    @(posedge axis_clk); #1;
    eng_active = 1'b0;
    n = 0;
    while (reads_done < target && n < 400) begin @(negedge axis_clk); n++; end
    chk("eng_reads_done", reads_done, target);
    ready_mode = 0;

    axi_write(12'h010, 32'h1234_5678, 4'hF);
    axi_read(12'h010);
    axi_read(12'h100);
    axi_write(12'h0AC, 32'hCAFE_0001, 4'hF);
    axi_read(12'h0AC);

    axi_write(12'h090, 32'h5A5A_0000, 4'hF);
    @(posedge axis_clk); #1;
    awaddr = 12'h090; wdata = 32'hFFFF_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge axis_clk);
    while (!awready && n < 50) begin @(negedge axis_clk); n++; end
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    axis_rst_n = 1'b0;
    #1;
    chk("rst_wr_tap_we", 32'(tap_WE), 32'h0);
    chk("rst_wr_tap_en", 32'(tap_EN), 32'h0);
    chk("rst_wr_bvalid", 32'(bvalid), 32'h0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    repeat (3) @(negedge axis_clk);
    chk("rst_wr_bvalid_after", 32'(bvalid), 32'h0);
    axi_read(12'h090);

    for (int i = 0; i < 80; i++) begin
      logic [11:0] a;
      a = (($urandom % 4) == 0) ? 12'($urandom) : 12'(12'h080 + ($urandom % 128));
      if ($urandom % 2) axi_write(a, $urandom, 4'($urandom));
      else axi_read(a);
    end

    repeat (5) @(negedge axis_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
